// File: rtl/conv_pkg.sv
// Shared types and helpers for the Sobel frame sequencer.
package conv_pkg;

   typedef enum logic [2:0] {IDLE, CLR, RUN, FLUSH, DONE} conv_state_t;

   // Bubble steps needed to push the last row's centres out of the 3x3 window.
   function automatic int unsigned flush_len(input int unsigned img_w);
      return img_w + 1;
   endfunction

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Source, filter-step and tagged-output signals between the sequencer and its neighbours.
interface conv_frame_ctrl_if #(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
);
   localparam int unsigned XW = $clog2(IMG_W);
   localparam int unsigned YW = $clog2(IMG_H);

   logic          src_valid;
   logic          src_ready;
   logic          flt_clr;
   logic          flt_step;
   logic          flt_bubble;
   logic          out_valid;
   logic          snk_ready;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          out_border;

   modport master (
      input  src_valid, snk_ready,
      output src_ready, flt_clr, flt_step, flt_bubble,
             out_valid, out_x, out_y, out_border
   );

   modport slave (
      output src_valid, snk_ready,
      input  src_ready, flt_clr, flt_step, flt_bubble,
             out_valid, out_x, out_y, out_border
   );
endinterface

// File: rtl/raster_xy_cnt.sv
// Raster-order (x,y) counter; x wraps at W-1 and carries into y, y wraps at H-1.
module raster_xy_cnt #(
   parameter int unsigned W = 640,
   parameter int unsigned H = 480
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   output logic [$clog2(W)-1:0] x,
   output logic [$clog2(H)-1:0] y,
   output logic                 last_x,
   output logic                 last_y
);
   localparam int unsigned XW = $clog2(W);
   localparam int unsigned YW = $clog2(H);

   assign last_x = (x == XW'(W - 1));
   assign last_y = (y == YW'(H - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (last_x) begin
            x <= '0;
            y <= last_y ? '0 : y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end
endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel filter: steps the window per pixel, flushes the
// line buffers with bubbles, and tags each result with its centre and border flag.
module conv_frame_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               frame_done,
   conv_frame_ctrl_if.master  bus
);
   localparam int unsigned XW        = $clog2(IMG_W);
   localparam int unsigned YW        = $clog2(IMG_H);
   localparam int unsigned FLUSH_LEN = flush_len(IMG_W);
   localparam int unsigned FW        = $clog2(FLUSH_LEN);

   conv_state_t   state;
   logic          out_valid;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          out_border;
   logic [FW-1:0] fl_cnt;

   logic [XW-1:0] in_x, cx;
   logic [YW-1:0] in_y, cy;
   logic          in_last_x, in_last_y, c_last_x, c_last_y;
   logic          can_step, step, in_en, produce, cnt_clr, fl_last;

   // Step/handshake decode; the output register is one deep, so a step needs room in it.
   always_comb begin
      can_step = 1'b0;
      step     = 1'b0;
      in_en    = 1'b0;
      produce  = 1'b0;
      cnt_clr  = 1'b0;
      fl_last  = 1'b0;

      can_step = !out_valid || bus.snk_ready;
      in_en    = (state == RUN) && bus.src_valid && can_step;
      step     = in_en || ((state == FLUSH) && can_step);
      // Window centre trails the input by IMG_W+1 steps; every flush step produces.
      produce  = step && ((state == FLUSH) || (in_y > YW'(1)) ||
                          ((in_y == YW'(1)) && (in_x != '0)));
      cnt_clr  = abort || (state == CLR);
      fl_last  = (fl_cnt == FW'(FLUSH_LEN - 1));
   end

   raster_xy_cnt #(.W(IMG_W), .H(IMG_H)) u_in_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .en     (in_en),
      .x      (in_x),
      .y      (in_y),
      .last_x (in_last_x),
      .last_y (in_last_y)
   );

   raster_xy_cnt #(.W(IMG_W), .H(IMG_H)) u_ctr_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .en     (produce),
      .x      (cx),
      .y      (cy),
      .last_x (c_last_x),
      .last_y (c_last_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_x      <= '0;
         out_y      <= '0;
         out_border <= 1'b0;
         fl_cnt     <= '0;
      end else if (abort) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         fl_cnt    <= '0;
      end else begin
         case (state)
            IDLE:    if (start) state <= CLR;
            CLR: begin
               state  <= RUN;
               fl_cnt <= '0;
            end
            RUN:     if (in_en && in_last_x && in_last_y) state <= FLUSH;
            FLUSH: begin
               if (step) begin
                  if (fl_last) begin
                     state  <= DONE;
                     fl_cnt <= '0;
                  end else begin
                     fl_cnt <= fl_cnt + FW'(1);
                  end
               end
            end
            DONE:    if (!out_valid) state <= IDLE;
            default: state <= IDLE;
         endcase

         // A new result overrides the accepted one in the same cycle.
         if (produce) begin
            out_valid  <= 1'b1;
            out_x      <= cx;
            out_y      <= cy;
            out_border <= (cx == '0) || c_last_x || (cy == '0) || c_last_y;
         end else if (bus.snk_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign busy           = (state != IDLE);
   assign frame_done     = (state == DONE) && !out_valid;
   assign bus.flt_clr    = (state == CLR);
   assign bus.flt_step   = step;
   assign bus.flt_bubble = (state == FLUSH);
   assign bus.src_ready  = (state == RUN) && can_step;
   assign bus.out_valid  = out_valid;
   assign bus.out_x      = out_x;
   assign bus.out_y      = out_y;
   assign bus.out_border = out_border;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl on a 4x3 frame with a step-index reference model.
module tb_conv_frame_ctrl;
   localparam int W      = 4;
   localparam int H      = 3;
   localparam int N      = W * H;
   localparam int LAST_K = N + W + 1;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic busy;
   logic frame_done;

   conv_frame_ctrl_if #(.IMG_W(W), .IMG_H(H)) bif ();

   conv_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .frame_done (frame_done),
      .bus        (bif)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // per-frame statistics gathered from DUT activity
   int st_hs, st_steps, st_bub, st_acc, st_nb, st_fd, st_clr;
   int first_x, first_y, last_x, last_y;

   // reference model: frame active, clear pending, steps taken, held output and its centre index
   bit m_busy = 1'b0;
   bit m_clr  = 1'b0;
   bit m_ov   = 1'b0;
   int m_k    = 0;
   int m_idx  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_stats();
      st_hs = 0; st_steps = 0; st_bub = 0; st_acc = 0; st_nb = 0; st_fd = 0; st_clr = 0;
      first_x = -1; first_y = -1; last_x = -1; last_y = -1;
   endtask

   // per-cycle comparison against the model, then model advance
   initial begin : compare
      bit running, flushing, can, e_step, eb;
      int ex, ey;
      forever begin
         @(negedge clk);
         running  = m_busy && !m_clr && (m_k < N);
         flushing = m_busy && !m_clr && (m_k >= N) && (m_k < LAST_K);
         can      = !m_ov || bif.snk_ready;
         e_step   = (running && bif.src_valid && can) || (flushing && can);

         check("flt_step",   int'(bif.flt_step),   int'(e_step));
         check("src_ready",  int'(bif.src_ready),  int'(running && can));
         check("flt_bubble", int'(bif.flt_bubble), int'(flushing));
         check("flt_clr",    int'(bif.flt_clr),    int'(m_busy && m_clr));
         check("busy",       int'(busy),           int'(m_busy));
         check("frame_done", int'(frame_done),
               int'(m_busy && !m_clr && (m_k == LAST_K) && !m_ov));
         check("out_valid",  int'(bif.out_valid),  int'(m_ov));
         if (m_ov) begin
            ex = m_idx % W;
            ey = m_idx / W;
            eb = (ex == 0) || (ex == W - 1) || (ey == 0) || (ey == H - 1);
            check("out_x",      int'(bif.out_x),      ex);
            check("out_y",      int'(bif.out_y),      ey);
            check("out_border", int'(bif.out_border), int'(eb));
         end

         if (bif.src_valid && bif.src_ready) st_hs++;
         if (bif.flt_step) begin
            st_steps++;
            if (bif.flt_bubble) st_bub++;
         end
         if (bif.flt_clr) st_clr++;
         if (frame_done) st_fd++;
         if (bif.out_valid && bif.snk_ready) begin
            check("seq_x", int'(bif.out_x), st_acc % W);
            check("seq_y", int'(bif.out_y), st_acc / W);
            if (!bif.out_border) st_nb++;
            if (st_acc == 0) begin
               first_x = int'(bif.out_x);
               first_y = int'(bif.out_y);
            end
            last_x = int'(bif.out_x);
            last_y = int'(bif.out_y);
            st_acc++;
         end

         if (rst || abort) begin
            m_busy = 1'b0; m_clr = 1'b0; m_k = 0; m_ov = 1'b0;
         end else begin
            if (!m_busy) begin
               if (start) begin
                  m_busy = 1'b1; m_clr = 1'b1; m_k = 0;
               end
            end else if (m_clr) begin
               m_clr = 1'b0;
            end else if ((m_k == LAST_K) && !m_ov) begin
               m_busy = 1'b0;
            end
            if (e_step) begin
               if (m_k >= W + 1) begin
                  m_ov  = 1'b1;
                  m_idx = m_k - (W + 1);
               end else if (bif.snk_ready) begin
                  m_ov = 1'b0;
               end
               m_k++;
            end else if (bif.snk_ready) begin
               m_ov = 1'b0;
            end
         end
      end
   end

   // One frame: vmode 0 = source always valid, 1 = valid on alternate cycles.
   // Negative arguments disable the stall / abort / reset / extra-start events.
   task automatic run_frame(input int vmode, input int stall_at, input int abort_hs,
                            input int rst_steps, input int restart_at);
      int  pending;
      bit  finished;
      pending  = 0;
      finished = 1'b0;
      clear_stats();
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         start         = (c == 0) || (c == restart_at);
         bif.src_valid = (vmode == 0) ? 1'b1 : ((c % 2) == 0);
         bif.snk_ready = !((stall_at >= 0) && (c >= stall_at) && (c < stall_at + 3));
         abort         = (pending == 0) && (abort_hs >= 0) && (st_hs == abort_hs);
         rst           = (pending == 0) && (rst_steps >= 0) && (st_steps == rst_steps);
         #1;
         if (pending == 1) begin
            check("abort_busy",       int'(busy),          0);
            check("abort_out_valid",  int'(bif.out_valid), 0);
            check("abort_frame_done", int'(frame_done),    0);
            finished = 1'b1;
            break;
         end
         if (pending == 2) begin
            check("rst_all_outputs",
                  int'({bif.src_ready, bif.flt_clr, bif.flt_step, bif.flt_bubble,
                        bif.out_valid, bif.out_border, busy, frame_done,
                        bif.out_x, bif.out_y}), 0);
            finished = 1'b1;
            break;
         end
         if ((stall_at >= 0) && (c >= stall_at) && (c < stall_at + 3)) begin
            check("stall_flt_step",  int'(bif.flt_step),  0);
            check("stall_src_ready", int'(bif.src_ready), 0);
            check("stall_out_valid", int'(bif.out_valid), 1);
            check("stall_out_x",     int'(bif.out_x),     0);
            check("stall_out_y",     int'(bif.out_y),     0);
         end
         if (frame_done) begin
            finished = 1'b1;
            break;
         end
         if (abort) pending = 1;
         if (rst)   pending = 2;
      end
      if (!finished) check("frame_timeout", 0, 1);
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      @(negedge clk); #1;
   endtask

   initial begin
      bif.src_valid = 1'b0;
      bif.snk_ready = 1'b0;
      clear_stats();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset_busy",      int'(busy),          0);
      check("reset_out_valid", int'(bif.out_valid), 0);
      check("reset_flt_clr",   int'(bif.flt_clr),   0);

      // basic frame
      run_frame(0, -1, -1, -1, -1);
      check("basic_handshakes", st_hs,    12);
      check("basic_steps",      st_steps, 17);
      check("basic_bubbles",    st_bub,   5);
      check("basic_outputs",    st_acc,   12);
      check("basic_inner",      st_nb,    2);
      check("basic_first_x",    first_x,  0);
      check("basic_first_y",    first_y,  0);
      check("basic_last_x",     last_x,   3);
      check("basic_last_y",     last_y,   2);
      check("basic_done",       st_fd,    1);
      check("basic_clr",        st_clr,   1);

      // sink stall mid-frame
      run_frame(0, 8, -1, -1, -1);
      check("stall_outputs", st_acc,   12);
      check("stall_steps",   st_steps, 17);
      check("stall_done",    st_fd,    1);

      // source gaps
      run_frame(1, -1, -1, -1, -1);
      check("gaps_handshakes", st_hs,    12);
      check("gaps_steps",      st_steps, 17);
      check("gaps_outputs",    st_acc,   12);
      check("gaps_inner",      st_nb,    2);
      check("gaps_last_x",     last_x,   3);
      check("gaps_last_y",     last_y,   2);

      // abort at input pixel 7, then a clean frame
      run_frame(0, -1, 7, -1, -1);
      check("abort_done_count", st_fd, 0);
      run_frame(0, -1, -1, -1, -1);
      check("post_abort_clr",     st_clr, 1);
      check("post_abort_outputs", st_acc, 12);
      check("post_abort_done",    st_fd,  1);

      // start pulsed during RUN is ignored
      run_frame(0, -1, -1, -1, 5);
      check("restart_clr",     st_clr,   1);
      check("restart_steps",   st_steps, 17);
      check("restart_outputs", st_acc,   12);

      // reset during FLUSH
      run_frame(0, -1, -1, 13, -1);
      check("rst_flush_done_count", st_fd, 0);

      // back-to-back frames
      run_frame(0, -1, -1, -1, -1);
      check("b2b1_clr",     st_clr, 1);
      check("b2b1_outputs", st_acc, 12);
      run_frame(0, -1, -1, -1, -1);
      check("b2b2_clr",     st_clr, 1);
      check("b2b2_outputs", st_acc, 12);
      check("b2b2_last_x",  last_x, 3);
      check("b2b2_last_y",  last_y, 2);
      check("b2b2_done",    st_fd,  1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
